// File: rtl/compressor12_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : compressor12_pkg
//  Description : Shared constants, FSM encoding and helpers for the 12-bit
//                compressor scheduling slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package compressor12_pkg;

    // Operand word width handled by the compressor datapath
    localparam int DATA_W = 12;

    // Scheduler state encoding
    typedef logic [1:0] state_t;
    localparam logic [1:0] c_ST_ACCEPT   = 2'd0;
    localparam logic [1:0] c_ST_COMPRESS = 2'd1;
    localparam logic [1:0] c_ST_DONE     = 2'd2;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/compressor12_sched_slice_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : slice_popcount
//  Description : Combinational ones-counter for one SLICE_W-bit slice. The
//                scheduler time-shares a single instance across all slices.
//  Revision    : 1.0 - initial release
// ============================================================================
module slice_popcount
    import compressor12_pkg::*;
#(
    parameter  int SLICE_W = 4,
    localparam int CNT_W   = clog2(SLICE_W + 1)
) (
    input  logic [SLICE_W-1:0] slice,
    output logic [CNT_W-1:0]   count
);

    // Sum the individual bits of the slice
    always_comb begin
        count = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            count = count + CNT_W'(slice[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/compressor12_sched.sv
`default_nettype none
// ============================================================================
//  Module      : compressor12_sched
//  Description : Accepts 12-bit words over valid/ready, feeds their slices LSB
//                first through one shared popcount, accumulates over a frame of
//                FRAME_LEN words and offers the frame total over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module compressor12_sched
    import compressor12_pkg::*;
#(
    parameter  int SLICE_W    = 4,
    parameter  int FRAME_LEN  = 8,
    localparam int SUM_W      = clog2(DATA_W * FRAME_LEN + 1),
    localparam int NUM_SLICES = DATA_W / SLICE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic              busy
);

    localparam int PC_W   = clog2(SLICE_W + 1);
    localparam int IDX_W  = (NUM_SLICES > 1) ? clog2(NUM_SLICES) : 1;
    localparam int WCNT_W = (FRAME_LEN > 1) ? clog2(FRAME_LEN) : 1;

    state_t             r_state;
    logic [DATA_W-1:0]  r_word;
    logic [IDX_W-1:0]   r_slice_idx;
    logic [WCNT_W-1:0]  r_word_cnt;
    logic [SUM_W-1:0]   r_acc;
    logic [SUM_W-1:0]   r_out_sum;

    logic [DATA_W-1:0]  w_shifted;
    logic [SLICE_W-1:0] w_slice;
    logic [PC_W-1:0]    w_slice_cnt;
    logic [SUM_W-1:0]   w_acc_next;
    logic               w_last_slice;
    logic               w_last_word;

    // Current slice selected by shifting the held word down, LSB slice first
    assign w_shifted    = r_word >> (int'(r_slice_idx) * SLICE_W);
    assign w_slice      = w_shifted[SLICE_W-1:0];
    assign w_acc_next   = r_acc + SUM_W'(w_slice_cnt);
    assign w_last_slice = (r_slice_idx == IDX_W'(NUM_SLICES - 1));
    assign w_last_word  = (r_word_cnt == WCNT_W'(FRAME_LEN - 1));

    slice_popcount #(
        .SLICE_W (SLICE_W)
    ) u_popcount (
        .slice (w_slice),
        .count (w_slice_cnt)
    );

    // Handshake and status outputs decode directly from the state register
    assign in_ready  = (r_state == c_ST_ACCEPT);
    assign out_valid = (r_state == c_ST_DONE);
    assign out_sum   = r_out_sum;
    assign busy      = !((r_state == c_ST_ACCEPT) && (r_word_cnt == '0));

    // Scheduler FSM with accumulator; clear overrides any handshake in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_ACCEPT;
            r_word      <= '0;
            r_slice_idx <= '0;
            r_word_cnt  <= '0;
            r_acc       <= '0;
            r_out_sum   <= '0;
        end else if (clear) begin
            r_state     <= c_ST_ACCEPT;
            r_slice_idx <= '0;
            r_word_cnt  <= '0;
            r_acc       <= '0;
        end else begin
            case (r_state)
                c_ST_ACCEPT: begin
                    if (in_valid) begin
                        r_word      <= in_data;
                        r_slice_idx <= '0;
                        r_state     <= c_ST_COMPRESS;
                    end
                end
                c_ST_COMPRESS: begin
                    r_acc <= w_acc_next;
                    if (!w_last_slice) begin
                        r_slice_idx <= r_slice_idx + IDX_W'(1);
                    end else if (w_last_word) begin
                        r_out_sum <= w_acc_next;
                        r_state   <= c_ST_DONE;
                    end else begin
                        r_word_cnt <= r_word_cnt + WCNT_W'(1);
                        r_state    <= c_ST_ACCEPT;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_acc      <= '0;
                        r_word_cnt <= '0;
                        r_state    <= c_ST_ACCEPT;
                    end
                end
                default: begin
                    r_state <= c_ST_ACCEPT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_compressor12_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compressor12_sched
//  Description : Directed self-checking bench for compressor12_sched, plus
//                single-word frames on three alternative slice widths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_compressor12_sched;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_sum;
    logic        busy;

    logic        sw_valid;
    logic [11:0] sw_data;
    logic        sw1_ready, sw3_ready, sw12_ready;
    logic        sw1_ovalid, sw3_ovalid, sw12_ovalid;
    logic [3:0]  sw1_sum, sw3_sum, sw12_sum;
    logic        sw1_busy, sw3_busy, sw12_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc;
    int prev_cyc;
    int out_cyc;

    compressor12_sched u_dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    compressor12_sched #(.SLICE_W(1), .FRAME_LEN(1)) u_sw1 (
        .clk (clk), .rst (rst), .clear (1'b0),
        .in_valid (sw_valid), .in_ready (sw1_ready), .in_data (sw_data),
        .out_valid (sw1_ovalid), .out_ready (1'b1), .out_sum (sw1_sum),
        .busy (sw1_busy)
    );

    compressor12_sched #(.SLICE_W(3), .FRAME_LEN(1)) u_sw3 (
        .clk (clk), .rst (rst), .clear (1'b0),
        .in_valid (sw_valid), .in_ready (sw3_ready), .in_data (sw_data),
        .out_valid (sw3_ovalid), .out_ready (1'b1), .out_sum (sw3_sum),
        .busy (sw3_busy)
    );

    compressor12_sched #(.SLICE_W(12), .FRAME_LEN(1)) u_sw12 (
        .clk (clk), .rst (rst), .clear (1'b0),
        .in_valid (sw_valid), .in_ready (sw12_ready), .in_data (sw_data),
        .out_valid (sw12_ovalid), .out_ready (1'b1), .out_sum (sw12_sum),
        .busy (sw12_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so latencies can be measured in cycles
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    // Present a word and hold it until accepted; with noisy set, in_data
    // carries a different value while the DUT is not ready.
    task automatic send(input logic [11:0] d, input bit noisy);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            if (noisy) in_data = ~d;
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("accept");
        in_data = d;
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout(tag);
        out_cyc = cyc;
        check(tag, 32'(out_sum), exp);
    endtask

    initial begin
        int seen1, seen3, seen12;
        int lat1, lat3, lat12;
        logic [3:0] s1, s3, s12;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_data = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum",   32'(out_sum),   0);
        check("rst_busy",      32'(busy),      0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp frame: one word every 4 cycles, total 36, result 3 edges later
        prev_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            send(12'((1 << (i + 1)) - 1), 1'b0);
            if (i > 0) check("ramp_interval", 32'(acc_cyc - prev_cyc), 4);
            prev_cyc = acc_cyc;
        end
        wait_out("ramp_sum", 36);
        check("ramp_latency", 32'(out_cyc - acc_cyc), 3);
        @(negedge clk);
        check("ramp_ovalid_drop", 32'(out_valid), 0);
        check("ramp_idle_ready",  32'(in_ready),  1);
        check("ramp_idle_busy",   32'(busy),      0);

        // Back-pressured result stays stable
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(12'hFFF, 1'b0);
        wait_out("bp_sum", 96);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_sum",   32'(out_sum),   96);
            check("bp_hold_ready", 32'(in_ready),  0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready),  1);
        check("bp_release_valid", 32'(out_valid), 0);

        // Clear during slice 1 of the third word discards the partial frame
        for (int i = 0; i < 3; i++) send(12'hFFF, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_ready",   32'(in_ready),  1);
        check("clr_busy",    32'(busy),      0);
        check("clr_ovalid",  32'(out_valid), 0);
        check("clr_keepsum", 32'(out_sum),   96);
        for (int i = 0; i < 8; i++) send(12'h800, 1'b0);
        wait_out("clr_next_sum", 8);
        @(negedge clk);

        // Data wiggling while the DUT compresses is not counted
        for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 12'hAAA : 12'h000, 1'b1);
        wait_out("noisy_sum", 24);
        @(negedge clk);

        // Asynchronous reset mid-COMPRESS
        send(12'hFFF, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("arst_in_ready",  32'(in_ready),  1);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_out_sum",   32'(out_sum),   0);
        check("arst_busy",      32'(busy),      0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send(12'hFFF, 1'b0);
        wait_out("arst_next_sum", 96);
        @(negedge clk);

        // Slice-width sweep with single-word frames
        check("sw1_ready",  32'(sw1_ready),  1);
        check("sw3_ready",  32'(sw3_ready),  1);
        check("sw12_ready", 32'(sw12_ready), 1);
        sw_valid = 1'b1;
        sw_data  = 12'h5A5;
        @(negedge clk);
        acc_cyc  = cyc;
        sw_valid = 1'b0;
        seen1 = 0; seen3 = 0; seen12 = 0;
        lat1 = -1; lat3 = -1; lat12 = -1;
        s1 = '0; s3 = '0; s12 = '0;
        for (int n = 0; n < 30; n++) begin
            if (sw1_ovalid && seen1 == 0)   begin seen1 = 1;  lat1 = cyc - acc_cyc;  s1 = sw1_sum;   end
            if (sw3_ovalid && seen3 == 0)   begin seen3 = 1;  lat3 = cyc - acc_cyc;  s3 = sw3_sum;   end
            if (sw12_ovalid && seen12 == 0) begin seen12 = 1; lat12 = cyc - acc_cyc; s12 = sw12_sum; end
            @(negedge clk);
        end
        check("sw1_sum",  32'(s1),  6);
        check("sw3_sum",  32'(s3),  6);
        check("sw12_sum", 32'(s12), 6);
        check("sw1_cycles",  32'(lat1),  12);
        check("sw3_cycles",  32'(lat3),  4);
        check("sw12_cycles", 32'(lat12), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard against a stalled run
    initial begin
        #500000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
